program_mem_arbiter: RTL and testbench

Shares the single read port of the global program memory between the per-core instruction fetchers using round-robin arbitration. It sits between the fetchers' ask/get read handshake and the program-memory controller, and serves one outstanding read at a time. Each fetcher sees the same protocol it would see if it owned the memory directly: hold the request, then receive a one-cycle acknowledge with data.

---
 rtl/gpu_mem_pkg.sv | 14 +
 rtl/rr_picker.sv | 31 +++
 rtl/program_mem_arbiter.sv | 92 +++++++++
 tb/tb_program_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the program-memory path.
package gpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQUEST, RESPOND, RELEASE} arb_state_t;

  localparam int PROG_MEM_ADDR_BITS = 8;
  localparam int PROG_MEM_DATA_BITS = 16;

  // Index width for a consumer count; at least one bit even for a single consumer.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
module rr_picker
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_W         = idx_bits(NUM_CONSUMERS)
) (
  input  logic [NUM_CONSUMERS-1:0] req,
  input  logic [IDX_W-1:0]         rr_ptr,
  output logic                     grant_found,
  output logic [IDX_W-1:0]         grant_idx
);

  // One extra bit so rr_ptr + offset never overflows before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CONSUMERS)) cand = cand - (IDX_W+1)'(NUM_CONSUMERS);
      if (!grant_found && req[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing the single program-memory read port among fetchers,
// one outstanding read at a time, presenting each fetcher a private ask/get handshake.
module program_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter  int NUM_CONSUMERS = 4,
  parameter  int ADDR_BITS     = PROG_MEM_ADDR_BITS,
  parameter  int DATA_BITS     = PROG_MEM_DATA_BITS,
  localparam int IDX_W         = idx_bits(NUM_CONSUMERS)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    busy,
  output logic [IDX_W-1:0]                        grant_id
);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             granted_valid;
  logic             load_grant;
  logic             capture;
  logic             release_done;

  rr_picker #(
    .NUM_CONSUMERS(NUM_CONSUMERS),
    .IDX_W        (IDX_W)
  ) u_picker (
    .req        (consumer_read_valid),
    .rr_ptr     (rr_ptr),
    .grant_found(pick_found),
    .grant_idx  (pick_idx)
  );

  assign granted_valid = consumer_read_valid[grant_id];
  assign ptr_next      = (grant_id == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_id + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // RELEASE waits for the served fetcher to drop its ask so a lingering valid is not served twice.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found)     state_next = REQUEST;
      REQUEST: if (mem_read_ready) state_next = RESPOND;
      RESPOND:                     state_next = RELEASE;
      RELEASE: if (!granted_valid) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Handshake outputs decode the state register only, so no input reaches an output combinationally.
  always_comb begin
    load_grant          = (state == IDLE) && pick_found;
    capture             = (state == REQUEST) && mem_read_ready;
    release_done        = (state == RELEASE) && !granted_valid;
    busy                = (state != IDLE);
    mem_read_valid      = (state == REQUEST);
    consumer_read_ready = '0;
    if (state == RESPOND) consumer_read_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr             <= '0;
      grant_id           <= '0;
      mem_read_address   <= '0;
      consumer_read_data <= '0;
    end else begin
      if (load_grant) begin
        grant_id         <= pick_idx;
        mem_read_address <= consumer_read_address[pick_idx];
      end
      if (capture)      consumer_read_data[grant_id] <= mem_read_data;
      if (release_done) rr_ptr                       <= ptr_next;
    end
  end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter: a 4-consumer instance with a wait-state memory
// model and reactive fetchers, plus a 3-consumer instance for non-power-of-two wrap.
module tb_program_mem_arbiter;
  import gpu_mem_pkg::*;

  typedef struct {
    int         id;
    logic [7:0] addr;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [15:0] mem_fn(input logic [7:0] a);
    return (a == 8'h1A) ? 16'hBEEF : {~a, a};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0]        cv;
  logic [3:0][7:0]   ca;
  logic [3:0]        cr;
  logic [3:0][15:0]  cd;
  logic              mv, mr;
  logic [7:0]        ma;
  logic [15:0]       md;
  logic              busy;
  logic [1:0]        gid;

  program_mem_arbiter #(.NUM_CONSUMERS(4), .ADDR_BITS(8), .DATA_BITS(16)) u_dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cv), .consumer_read_address(ca),
    .consumer_read_ready(cr), .consumer_read_data(cd),
    .mem_read_valid(mv), .mem_read_address(ma),
    .mem_read_ready(mr), .mem_read_data(md),
    .busy(busy), .grant_id(gid)
  );

  logic [2:0]        cv3;
  logic [2:0][7:0]   ca3;
  logic [2:0]        cr3;
  logic [2:0][15:0]  cd3;
  logic              mv3;
  logic [7:0]        ma3;
  logic [15:0]       md3;
  logic              busy3;
  logic [1:0]        gid3;

  assign md3 = mem_fn(ma3);

  program_mem_arbiter #(.NUM_CONSUMERS(3), .ADDR_BITS(8), .DATA_BITS(16)) u_dut3 (
    .clk(clk), .reset(reset),
    .consumer_read_valid(cv3), .consumer_read_address(ca3),
    .consumer_read_ready(cr3), .consumer_read_data(cd3),
    .mem_read_valid(mv3), .mem_read_address(ma3),
    .mem_read_ready(1'b1), .mem_read_data(md3),
    .busy(busy3), .grant_id(gid3)
  );

  exp_t sb4[$];
  exp_t sb3[$];
  exp_t e4, e3;
  int   hold[4], hold_left[4], rearm[4], rearm_wait[4];
  int   mem_wait = 0;
  int   mem_cnt  = 0;
  bit   mem_always = 1'b0;
  bit   prev_pulse = 1'b0;

  task automatic drop(input int i);
    cv[i] = 1'b0;
    if (rearm[i] > 0) begin
      rearm[i]--;
      rearm_wait[i] = 2;
    end
  endtask

  // Memory model and fetchers for the 4-consumer instance, all acting on the falling edge.
  always @(negedge clk) begin
    if (mem_always) begin
      mr = 1'b1;
      md = mem_fn(ma);
    end else if (mv) begin
      mr = (mem_cnt >= mem_wait);
      md = mr ? mem_fn(ma) : 16'h0;
      mem_cnt++;
    end else begin
      mr      = 1'b0;
      mem_cnt = 0;
    end

    for (int i = 0; i < 4; i++) begin
      if (hold_left[i] > 0) begin
        hold_left[i]--;
        if (hold_left[i] == 0) drop(i);
      end
      if (rearm_wait[i] > 0) begin
        rearm_wait[i]--;
        if (rearm_wait[i] == 0) cv[i] = 1'b1;
      end
    end

    if (prev_pulse) check_val("pulse_width", cr, 0);
    prev_pulse = (cr != 0);
    if (cr != 0) begin
      if (sb4.size() == 0) check_val("unexpected_pulse", cr, 0);
      else begin
        e4 = sb4.pop_front();
        check_val("grant_onehot", cr, 1 << e4.id);
        check_val("grant_id", gid, e4.id);
        check_val("read_data", cd[e4.id], mem_fn(e4.addr));
        check_val("mem_addr", ma, e4.addr);
      end
      for (int i = 0; i < 4; i++)
        if (cr[i]) begin
          if (hold[i] > 0) hold_left[i] = hold[i];
          else drop(i);
        end
    end
  end

  always @(negedge clk) begin
    if (cr3 != 0) begin
      if (sb3.size() == 0) check_val("dut3_unexpected", cr3, 0);
      else begin
        e3 = sb3.pop_front();
        check_val("dut3_onehot", cr3, 1 << e3.id);
        check_val("dut3_grant", gid3, e3.id);
        check_val("dut3_data", cd3[e3.id], mem_fn(e3.addr));
      end
      cv3 = cv3 & ~cr3;
    end
  end

  task automatic req4(input int i, input logic [7:0] a);
    ca[i] = a;
    cv[i] = 1'b1;
  endtask

  task automatic expect4(input int i);
    sb4.push_back('{i, ca[i]});
  endtask

  task automatic req3(input int i, input logic [7:0] a);
    ca3[i] = a;
    cv3[i] = 1'b1;
    sb3.push_back('{i, a});
  endtask

  task automatic drain4(input string tag);
    int n = 0;
    while ((sb4.size() != 0 || busy || cv != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, sb4.size(), 0);
  endtask

  task automatic drain3(input string tag);
    int n = 0;
    while ((sb3.size() != 0 || busy3 || cv3 != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, sb3.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cv = '0; ca = '0; cv3 = '0; ca3 = '0; mr = 1'b0; md = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_mem_valid", mv, 0);
    check_val("rst_ready", cr, 0);
    check_val("rst_grant", gid, 0);
    check_val("rst_addr", ma, 0);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_busy", busy, 0);

    // Three consumers: rr_ptr reaches 2, then must wrap to 0.
    req3(1, 8'h71);
    drain3("dut3_a");
    req3(2, 8'h72); req3(0, 8'h70);
    drain3("dut3_b");
    req3(2, 8'h82);
    drain3("dut3_c");
    req3(0, 8'h90); req3(1, 8'h91);
    drain3("dut3_d");

    // All four requesting continuously, two rounds each.
    for (int i = 0; i < 4; i++) begin
      rearm[i] = 1;
      req4(i, 8'h10 + 8'(i));
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) expect4(i);
    drain4("rr_all");

    // Single request with three memory wait cycles.
    mem_wait = 3;
    req4(2, 8'h1A); expect4(2);
    drain4("single");
    check_val("single_data", cd[2], 16'hBEEF);
    mem_wait = 0;

    // Served consumer lingers on valid for five cycles.
    hold[0] = 5;
    req4(0, 8'h40); expect4(0);
    req4(1, 8'h41); expect4(1);
    n = 0;
    while (!cr[0] && n < 50) begin @(negedge clk); n++; end
    check_val("hold_pulse_seen", cr[0], 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("hold_busy", busy, 1);
      check_val("hold_no_req", mv, 0);
    end
    drain4("hold");
    hold[0] = 0;

    // Memory ready held permanently.
    mem_always = 1'b1;
    req4(1, 8'h51); req4(3, 8'h53);
    expect4(3); expect4(1);
    drain4("always_ready");
    mem_always = 1'b0;
    @(negedge clk);

    // Best-case ask-to-get latency.
    req4(0, 8'h60); expect4(0);
    @(negedge clk);
    check_val("lat_mem_valid", mv, 1);
    check_val("lat_mem_addr", ma, 8'h60);
    @(negedge clk);
    check_val("lat_ready", cr[0], 1);
    drain4("latency");

    // Reset asserted while a read is outstanding.
    mem_wait = 20;
    req4(3, 8'h33);
    n = 0;
    while (!mv && n < 20) begin @(negedge clk); n++; end
    check_val("rst_req_reached", mv, 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_mem_valid", mv, 0);
    check_val("async_busy", busy, 0);
    check_val("async_grant", gid, 0);
    check_val("async_data", cd[3], 0);
    @(negedge clk);
    mem_wait = 0;
    req4(1, 8'h31); req4(2, 8'h32);
    @(negedge clk);
    reset = 1'b1;
    expect4(1); expect4(2); expect4(3);
    drain4("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
